// File: rtl/cmd_decoder.sv
// Host command decoder: parses the rx FIFO byte stream into settings-register writes,
// busy-gated start pulses, config words and register read-backs.
module cmd_decoder #(
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned REG_W          = 8,
  parameter int unsigned NUM_TOGGLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_rdata,
  input  logic                      rx_rempty,
  output logic                      rx_rinc,
  input  logic [NUM_TOGGLES-1:0]    busy,
  output logic [NUM_TOGGLES-1:0]    toggle,
  output logic [15:0]               word_out,
  output logic                      word_strobe,
  input  logic                      word_busy,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [15:0]               resp_data,
  output logic                      soft_rst,
  output logic                      err,
  output logic [7:0]                err_count
);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StDecode, StPayload, StExec, StWaitBusy, StResp} state_e;

  state_e                         state_q, state_d;
  logic [7:0]                     cmd_q, cmd_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic [23:0]                    pay_q, pay_d;
  logic [TimerW-1:0]              timer_q, timer_d;
  logic [NUM_REGS-1:0][REG_W-1:0] regs_q, regs_d;
  logic [NUM_TOGGLES-1:0]         toggle_q, toggle_d;
  logic [15:0]                    word_q, word_d;
  logic                           strobe_q, strobe_d;
  logic                           rv_q, rv_d;
  logic [15:0]                    rdata_q, rdata_d;
  logic                           soft_q, soft_d;
  logic                           err_q, err_d;
  logic [7:0]                     errc_q, errc_d;

  logic                   is_reset, is_toggle, is_write, is_read, is_word;
  logic [3:0]             tog_idx;
  logic                   tog_ok;
  logic [NUM_TOGGLES-1:0] tog_sel;
  logic                   gate_busy;
  logic [7:0]             addr;
  logic                   addr_ok;
  logic [REG_W-1:0]       rd_val;
  logic [15:0]            rd_ext;
  logic                   timed_out;
  logic                   fire;
  logic                   raise_err;

  assign is_reset  = (cmd_q == 8'h01);
  assign is_toggle = (cmd_q[7:4] == 4'h1);
  assign is_write  = (cmd_q == 8'h20);
  assign is_read   = (cmd_q == 8'h21);
  assign is_word   = (cmd_q == 8'h22);
  assign tog_idx   = cmd_q[3:0];
  assign tog_ok    = (32'(tog_idx) < NUM_TOGGLES);
  // WRITE shifts in {addr,msb,lsb}; READ leaves its single addr byte at the bottom.
  assign addr      = is_write ? pay_q[23:16] : pay_q[7:0];
  assign addr_ok   = (32'(addr) < NUM_REGS);
  assign timed_out = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
  assign rd_ext    = 16'(rd_val);
  assign gate_busy = is_toggle ? |(busy & tog_sel) : word_busy;

  always_comb begin
    tog_sel = '0;
    for (int unsigned i = 0; i < NUM_TOGGLES; i++) tog_sel[i] = (32'(tog_idx) == i);
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(addr) == i) rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    pay_d     = pay_q;
    timer_d   = timer_q;
    regs_d    = regs_q;
    toggle_d  = '0;
    word_d    = word_q;
    strobe_d  = 1'b0;
    rv_d      = rv_q;
    rdata_d   = rdata_q;
    soft_d    = 1'b0;
    err_d     = 1'b0;
    errc_d    = errc_q;
    rx_rinc   = 1'b0;
    fire      = 1'b0;
    raise_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_rempty) begin
          rx_rinc = 1'b1;
          cmd_d   = rx_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_reset || (is_toggle && tog_ok)) begin
          cnt_d   = 2'd0;
          state_d = StExec;
        end else if (is_write) begin
          cnt_d   = 2'd3;
          state_d = StPayload;
        end else if (is_read) begin
          cnt_d   = 2'd1;
          state_d = StPayload;
        end else if (is_word) begin
          cnt_d   = 2'd2;
          state_d = StPayload;
        end else begin
          raise_err = 1'b1;
        end
      end
      StPayload: begin
        if (!rx_rempty) begin
          rx_rinc = 1'b1;
          pay_d   = {pay_q[15:0], rx_rdata};
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = StExec;
        end else if (timed_out) begin
          raise_err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StExec: begin
        state_d = StIdle;
        if (is_reset) begin
          soft_d = 1'b1;
          regs_d = '0;
        end else if (is_write) begin
          if (addr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (32'(addr) == i) regs_d[i] = pay_q[REG_W-1:0];
            end
          end else begin
            raise_err = 1'b1;
          end
        end else if (is_read) begin
          if (addr_ok) begin
            rv_d    = 1'b1;
            rdata_d = (REG_W <= 8) ? {addr, rd_ext[7:0]} : rd_ext;
            state_d = StResp;
          end else begin
            raise_err = 1'b1;
          end
        end else if (!gate_busy) begin
          fire = 1'b1;
        end else begin
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!gate_busy) begin
          fire    = 1'b1;
          state_d = StIdle;
        end else if (timed_out) begin
          raise_err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fire) begin
      if (is_toggle) begin
        toggle_d = tog_sel;
      end else begin
        word_d   = pay_q[15:0];
        strobe_d = 1'b1;
      end
    end

    if (raise_err) begin
      err_d   = 1'b1;
      errc_d  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
      state_d = StIdle;
    end

    // The idle timer measures stalls only: any pop or state change restarts it.
    if (rx_rinc || (state_d != state_q)) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      cnt_q    <= '0;
      pay_q    <= '0;
      timer_q  <= '0;
      regs_q   <= '0;
      toggle_q <= '0;
      word_q   <= '0;
      strobe_q <= 1'b0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      soft_q   <= 1'b0;
      err_q    <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      pay_q    <= pay_d;
      timer_q  <= timer_d;
      regs_q   <= regs_d;
      toggle_q <= toggle_d;
      word_q   <= word_d;
      strobe_q <= strobe_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
      soft_q   <= soft_d;
      err_q    <= err_d;
      errc_q   <= errc_d;
    end
  end

  assign toggle      = toggle_q;
  assign word_out    = word_q;
  assign word_strobe = strobe_q;
  assign regs_flat   = regs_q;
  assign resp_valid  = rv_q;
  assign resp_data   = rdata_q;
  assign soft_rst    = soft_q;
  assign err         = err_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Randomised scoreboard bench for cmd_decoder: a byte-queue FIFO feeds commands,
// a transaction-level model predicts every output event and the register file.
`timescale 1ns/1ps
module tb_cmd_decoder;
  localparam int unsigned NR = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned NT = 4;
  localparam int unsigned TO = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_rdata = 8'h00;
  logic             rx_rempty = 1'b1;
  logic             rx_rinc;
  logic [NT-1:0]    busy = '0;
  logic [NT-1:0]    toggle;
  logic [15:0]      word_out;
  logic             word_strobe;
  logic             word_busy = 1'b0;
  logic [NR*RW-1:0] regs_flat;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [15:0]      resp_data;
  logic             soft_rst;
  logic             err;
  logic [7:0]       err_count;

  cmd_decoder #(
    .NUM_REGS(NR), .REG_W(RW), .NUM_TOGGLES(NT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdata(rx_rdata), .rx_rempty(rx_rempty),
    .rx_rinc(rx_rinc), .busy(busy), .toggle(toggle), .word_out(word_out),
    .word_strobe(word_strobe), .word_busy(word_busy), .regs_flat(regs_flat),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .soft_rst(soft_rst), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef enum int {EvToggle, EvWord, EvResp, EvSoftRst, EvErr} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       data;
  } ev_t;

  ev_t         exp_q[$];
  byte unsigned fifo[$];
  int          checks = 0;
  int          errors = 0;
  logic [RW-1:0] model_regs[NR];
  int          model_errc = 0;
  int          rdy_low = 0;
  logic        pop_now = 1'b0;
  logic [NT-1:0] prev_busy = '0;
  logic        prev_wbusy = 1'b0;
  logic        prev_rv = 1'b0;
  logic        prev_hs = 1'b0;
  logic [15:0] prev_rd = '0;

  // FIFO model: pop on the edge where the DUT requested it, present the new head shortly after.
  always @(negedge clk) pop_now = rx_rinc;
  always @(posedge clk) begin
    if (pop_now) begin
      checks++;
      if (fifo.size() == 0) begin
        errors++;
        $display("FAIL rinc_when_empty: rx_rinc=1 with empty FIFO, required 0");
      end else begin
        void'(fifo.pop_front());
      end
    end
    #2;
    rx_rempty = (fifo.size() == 0);
    rx_rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_low > 0) begin
      resp_ready = 1'b0;
      rdy_low--;
    end else begin
      resp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic expect_ev(input ev_kind_e kind, input int got, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, got data %0h, required no event", name, got);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != got) begin
        errors++;
        $display("FAIL %s: got kind %0d data %0h, required kind %0d data %0h",
                 name, kind, got, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every pulse or handshake consumes one predicted event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|toggle) begin
        int idx = 0;
        for (int i = 0; i < int'(NT); i++) if (toggle[i]) idx = i;
        checks++;
        if ($countones(toggle) != 1 || (prev_busy & toggle) != '0) begin
          errors++;
          $display("FAIL toggle_gating: toggle=%0h busy_before=%0h, required one-hot while not busy",
                   toggle, prev_busy);
        end
        expect_ev(EvToggle, idx, "toggle");
      end
      if (word_strobe) begin
        checks++;
        if (prev_wbusy) begin
          errors++;
          $display("FAIL word_gating: strobe with word_busy=1, required word_busy=0");
        end
        expect_ev(EvWord, int'(word_out), "word");
      end
      if (prev_rv && !prev_hs) begin
        checks++;
        if (!resp_valid || resp_data != prev_rd) begin
          errors++;
          $display("FAIL resp_hold: got valid=%0b data=%0h, required valid=1 data=%0h",
                   resp_valid, resp_data, prev_rd);
        end
      end
      if (resp_valid && resp_ready) expect_ev(EvResp, int'(resp_data), "resp");
      if (soft_rst) expect_ev(EvSoftRst, 0, "soft_rst");
      if (err) expect_ev(EvErr, int'(err_count), "err");
    end
    prev_busy  = busy;
    prev_wbusy = word_busy;
    prev_rv    = resp_valid && rst_n;
    prev_hs    = resp_valid && resp_ready;
    prev_rd    = resp_data;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_err();
    model_errc = (model_errc == 255) ? 255 : model_errc + 1;
    exp_q.push_back('{kind: EvErr, data: model_errc});
  endtask

  task automatic send(input byte unsigned b, input int gap);
    if (gap > 0) cyc(gap);
    fifo.push_back(b);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_timeout: %0d events / %0d bytes outstanding, required 0",
               exp_q.size(), fifo.size());
      exp_q.delete();
      fifo.delete();
    end
    cyc(6);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < int'(NR); i++) begin
      checks++;
      if (regs_flat[i*RW +: RW] != model_regs[i]) begin
        errors++;
        $display("FAIL %s reg%0d: got %0h, required %0h", name, i, regs_flat[i*RW +: RW],
                 model_regs[i]);
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic do_write(input int a, input byte unsigned msb, input byte unsigned lsb,
                          input int gmax);
    if (a < int'(NR)) model_regs[a] = RW'({msb, lsb});
    else push_err();
    send(8'h20, 0);
    send(8'(a), $urandom_range(0, gmax));
    send(msb, $urandom_range(0, gmax));
    send(lsb, $urandom_range(0, gmax));
    wait_done(400);
    check_regs("write");
  endtask

  task automatic do_read(input int a);
    logic [7:0] v8;
    v8 = 8'(model_regs[a]);
    exp_q.push_back('{kind: EvResp, data: int'({8'(a), v8})});
    send(8'h21, 0);
    send(8'(a), $urandom_range(0, 3));
    wait_done(400);
  endtask

  task automatic do_toggle(input int k, input int d);
    if (k >= int'(NT)) push_err();
    else if (d > int'(TO) + 20) push_err();
    else exp_q.push_back('{kind: EvToggle, data: k});
    if (k < int'(NT) && d > 0) busy[k] = 1'b1;
    send(8'(8'h10 + k), 0);
    if (k < int'(NT)) begin
      cyc(d);
      busy[k] = 1'b0;
    end
    wait_done(400);
  endtask

  task automatic do_word(input logic [15:0] w, input int d);
    if (d > int'(TO) + 20) push_err();
    else exp_q.push_back('{kind: EvWord, data: int'(w)});
    if (d > 0) word_busy = 1'b1;
    send(8'h22, 0);
    send(w[15:8], $urandom_range(0, 3));
    send(w[7:0], $urandom_range(0, 3));
    cyc(d);
    word_busy = 1'b0;
    wait_done(400);
  endtask

  task automatic do_soft_reset();
    exp_q.push_back('{kind: EvSoftRst, data: 0});
    for (int i = 0; i < int'(NR); i++) model_regs[i] = '0;
    send(8'h01, 0);
    wait_done(400);
    check_regs("soft_reset");
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, "_toggle"}, int'(toggle), 0);
    check_val({name, "_word_out"}, int'(word_out), 0);
    check_val({name, "_word_strobe"}, int'(word_strobe), 0);
    check_val({name, "_regs"}, int'(regs_flat), 0);
    check_val({name, "_resp_valid"}, int'(resp_valid), 0);
    check_val({name, "_resp_data"}, int'(resp_data), 0);
    check_val({name, "_soft_rst"}, int'(soft_rst), 0);
    check_val({name, "_err"}, int'(err), 0);
    check_val({name, "_err_count"}, int'(err_count), 0);
    check_val({name, "_rx_rinc"}, int'(rx_rinc), 0);
  endtask

  initial begin
    byte unsigned bad_ops[8];
    bad_ops = '{8'h00, 8'h02, 8'h0F, 8'h23, 8'h7F, 8'hFF, 8'h80, 8'h30};
    for (int i = 0; i < int'(NR); i++) model_regs[i] = '0;

    #1;
    check_all_zero("reset");
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Directed scenarios
    do_write(1, 8'h12, 8'h34, 0);
    check_val("reg1_after_write", int'(regs_flat[1*RW +: RW]), 'h34);
    rdy_low = 10;
    do_read(1);
    busy[2] = 1'b1;
    exp_q.push_back('{kind: EvToggle, data: 2});
    send(8'h12, 0);
    cyc(10);
    busy[2] = 1'b0;
    wait_done(400);
    push_err();
    send(8'h7F, 0);
    wait_done(400);
    do_write(9, 8'h00, 8'h00, 0);
    check_val("err_count_two", int'(err_count), 2);
    push_err();
    send(8'h20, 0);
    send(8'h01, 0);
    cyc(TO + 20);
    wait_done(400);
    do_word(16'hABCD, 0);
    check_val("word_held", int'(word_out), 'hABCD);

    // Randomised traffic
    for (int it = 0; it < 120; it++) begin
      int sel = $urandom_range(0, 9);
      int d = ($urandom_range(0, 9) == 0) ? int'(TO) + 60 : $urandom_range(0, 25);
      case (sel)
        0, 1, 2: do_write($urandom_range(0, 5), 8'($urandom), 8'($urandom), 3);
        3, 4:    do_read($urandom_range(0, int'(NR) - 1));
        5, 6:    do_toggle($urandom_range(0, 5), d);
        7:       do_word(16'($urandom), d);
        8: begin
          push_err();
          send(bad_ops[$urandom_range(0, 7)], 0);
          wait_done(400);
        end
        default: do_soft_reset();
      endcase
    end
    check_regs("random_end");

    // Error counter saturation, then a soft reset must keep the count.
    for (int i = 0; i < 260; i++) begin
      push_err();
      fifo.push_back(8'hFF);
    end
    wait_done(3000);
    check_val("err_count_sat", int'(err_count), 255);
    do_soft_reset();
    check_val("err_count_kept", int'(err_count), 255);

    // Asynchronous reset while a toggle waits on busy: no pulse may follow.
    busy[1] = 1'b1;
    send(8'h11, 0);
    cyc(8);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    model_errc = 0;
    for (int i = 0; i < int'(NR); i++) model_regs[i] = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    busy[1] = 1'b0;
    cyc(20);
    check_val("no_events_after_reset", exp_q.size(), 0);
    check_all_zero("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
